// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: fixed-priority grant of the shared cmd/ba/addr/CKE bus.
// Optional grant watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
  parameter logic [3:0]  CMD_NOP     = 4'b0111,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic [17:0] init_bus,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [17:0] aref_bus,
  output logic        aref_en,
  input  logic        sref_req,
  input  logic        sref_end,
  input  logic        sref_cke,
  input  logic [17:0] sref_bus,
  output logic        sref_en,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [17:0] wr_bus,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [17:0] rd_bus,
  output logic        rd_en,
`ifdef SDRAM_ARB_TIMEOUT_EN
  output logic        arb_timeout,
`endif
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_SREF  = 3'd3,
    ST_WRITE = 3'd4,
    ST_READ  = 3'd5
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   wdog_fire_s;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wdog_cnt_r;
  logic             wdog_st_s;
  logic             grant_end_s;

  // Watchdog fires on the last allowed cycle of an AREF/WRITE/READ grant that has not ended.
  always_comb begin
    wdog_st_s   = (state_r == ST_AREF) || (state_r == ST_WRITE) || (state_r == ST_READ);
    grant_end_s = ((state_r == ST_AREF)  && aref_end) ||
                  ((state_r == ST_WRITE) && wr_end)   ||
                  ((state_r == ST_READ)  && rd_end);
    wdog_fire_s = wdog_st_s && !grant_end_s &&
                  (wdog_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Grant-cycle counter; restarts at zero whenever the state changes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s != state_r) || !wdog_st_s) begin
      wdog_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wdog_cnt_r <= wdog_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign arb_timeout = wdog_fire_s;
`else
  assign wdog_fire_s = 1'b0;
`endif

  // Next-state: priority arbitration in ARBIT, hold grant until its own end (or watchdog).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_done) state_nxt_s = ST_ARBIT;
        else           state_nxt_s = ST_INIT;
      end
      ST_ARBIT: begin
        if (sref_req)      state_nxt_s = ST_SREF;
        else if (aref_req) state_nxt_s = ST_AREF;
        else if (wr_req)   state_nxt_s = ST_WRITE;
        else if (rd_req)   state_nxt_s = ST_READ;
        else               state_nxt_s = ST_ARBIT;
      end
      ST_AREF: begin
        if (aref_end || wdog_fire_s) state_nxt_s = ST_ARBIT;
        else                         state_nxt_s = ST_AREF;
      end
      ST_SREF: begin
        if (sref_end) state_nxt_s = ST_ARBIT;
        else          state_nxt_s = ST_SREF;
      end
      ST_WRITE: begin
        if (wr_end || wdog_fire_s) state_nxt_s = ST_ARBIT;
        else                       state_nxt_s = ST_WRITE;
      end
      ST_READ: begin
        if (rd_end || wdog_fire_s) state_nxt_s = ST_ARBIT;
        else                       state_nxt_s = ST_READ;
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register; reset returns to INIT even in the middle of a grant.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_r <= ST_INIT;
    else            state_r <= state_nxt_s;
  end

  // Output decode straight from the state so a grant hands over the bus without delay.
  always_comb begin
    sdram_cke = 1'b1;
    {sdram_cmd, sdram_ba, sdram_addr} = {CMD_NOP, 2'b11, 12'hFFF};
    aref_en = 1'b0;
    sref_en = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_r)
      ST_INIT:  {sdram_cmd, sdram_ba, sdram_addr} = init_bus;
      ST_ARBIT: {sdram_cmd, sdram_ba, sdram_addr} = {CMD_NOP, 2'b11, 12'hFFF};
      ST_AREF: begin
        aref_en = 1'b1;
        {sdram_cmd, sdram_ba, sdram_addr} = aref_bus;
      end
      ST_SREF: begin
        sref_en   = 1'b1;
        sdram_cke = sref_cke;
        {sdram_cmd, sdram_ba, sdram_addr} = sref_bus;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        {sdram_cmd, sdram_ba, sdram_addr} = wr_bus;
      end
      ST_READ: begin
        rd_en = 1'b1;
        {sdram_cmd, sdram_ba, sdram_addr} = rd_bus;
      end
      default: {sdram_cmd, sdram_ba, sdram_addr} = init_bus;
    endcase
  end

endmodule
